// File: rtl/i2c_master_arbiter_if.sv
// Command/response bundle between the arbiter and one I2C master core.
// master: arbiter side (drives command). slave: core side.
interface i2c_master_arbiter_if;
    logic        i2c_en;
    logic        start;
    logic [1:0]  mode;
    logic [6:0]  slave_addr;
    logic [7:0]  reg_addr;
    logic [1:0]  burst_len;
    logic [31:0] tx_data;
    logic        ready;
    logic        done;
    logic [31:0] rx_data;
    logic        rx_done_final;

    modport master (
        output i2c_en,
        output start,
        output mode,
        output slave_addr,
        output reg_addr,
        output burst_len,
        output tx_data,
        input  ready,
        input  done,
        input  rx_data,
        input  rx_done_final
    );

    modport slave (
        input  i2c_en,
        input  start,
        input  mode,
        input  slave_addr,
        input  reg_addr,
        input  burst_len,
        input  tx_data,
        output ready,
        output done,
        output rx_data,
        output rx_done_final
    );
endinterface

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one I2C master core between two
// requesters. Ports: clk, reset (sync, active high); per requester n:
// req_n, mode_n, slave_addr_n, reg_addr_n, burst_len_n, tx_data_n in,
// gnt_n, done_n, err_n, rx_data_n out; core: i2c_master_arbiter_if.master.
module i2c_master_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned RECOVER_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_0,
    input  logic        req_1,
    input  logic [1:0]  mode_0,
    input  logic [1:0]  mode_1,
    input  logic [6:0]  slave_addr_0,
    input  logic [6:0]  slave_addr_1,
    input  logic [7:0]  reg_addr_0,
    input  logic [7:0]  reg_addr_1,
    input  logic [1:0]  burst_len_0,
    input  logic [1:0]  burst_len_1,
    input  logic [31:0] tx_data_0,
    input  logic [31:0] tx_data_1,
    output logic        gnt_0,
    output logic        gnt_1,
    output logic        done_0,
    output logic        done_1,
    output logic        err_0,
    output logic        err_1,
    output logic [31:0] rx_data_0,
    output logic [31:0] rx_data_1,
    i2c_master_arbiter_if.master core
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        COOL,
        RECOVER
    } state_t;

    localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 32'd1;
    localparam logic [31:0] RC_LAST = RECOVER_CYCLES - 32'd1;

    state_t      state;
    logic [31:0] cnt;
    logic        owner;
    logic        last_owner;

    logic        grant_ok;
    logic        pick;
    logic        timeout_hit;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_ok    = core.ready & (req_0 | req_1);
        pick        = (req_0 & req_1) ? ~last_owner : req_1;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            owner           <= 1'b0;
            last_owner      <= 1'b1;
            gnt_0           <= 1'b0;
            gnt_1           <= 1'b0;
            done_0          <= 1'b0;
            done_1          <= 1'b0;
            err_0           <= 1'b0;
            err_1           <= 1'b0;
            rx_data_0       <= '0;
            rx_data_1       <= '0;
            core.i2c_en     <= 1'b0;
            core.start      <= 1'b0;
            core.mode       <= '0;
            core.slave_addr <= '0;
            core.reg_addr   <= '0;
            core.burst_len  <= '0;
            core.tx_data    <= '0;
        end else begin
            done_0 <= 1'b0;
            done_1 <= 1'b0;
            err_0  <= 1'b0;
            err_1  <= 1'b0;
            unique case (state)
                IDLE: begin
                    core.i2c_en <= 1'b1;
                    if (grant_ok) begin
                        owner           <= pick;
                        gnt_0           <= ~pick;
                        gnt_1           <= pick;
                        core.mode       <= pick ? mode_1 : mode_0;
                        core.slave_addr <= pick ? slave_addr_1
                                                : slave_addr_0;
                        core.reg_addr   <= pick ? reg_addr_1
                                                : reg_addr_0;
                        core.burst_len  <= pick ? burst_len_1
                                                : burst_len_0;
                        core.tx_data    <= pick ? tx_data_1
                                                : tx_data_0;
                        core.start      <= 1'b1;
                        cnt             <= '0;
                        state           <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 32'd1;
                    // done takes priority over a timeout in the same cycle
                    if (core.done) begin
                        if (core.rx_done_final) begin
                            if (owner) rx_data_1 <= core.rx_data;
                            else       rx_data_0 <= core.rx_data;
                        end
                        done_0     <= ~owner;
                        done_1     <= owner;
                        core.start <= 1'b0;
                        gnt_0      <= 1'b0;
                        gnt_1      <= 1'b0;
                        last_owner <= owner;
                        state      <= COOL;
                    end else if (timeout_hit) begin
                        err_0       <= ~owner;
                        err_1       <= owner;
                        core.start  <= 1'b0;
                        core.i2c_en <= 1'b0;
                        gnt_0       <= 1'b0;
                        gnt_1       <= 1'b0;
                        last_owner  <= owner;
                        cnt         <= '0;
                        state       <= RECOVER;
                    end else if (core.rx_done_final) begin
                        if (owner) rx_data_1 <= core.rx_data;
                        else       rx_data_0 <= core.rx_data;
                    end
                end
                // One idle cycle so the core sees start low before regrant.
                COOL: begin
                    state <= IDLE;
                end
                RECOVER: begin
                    cnt <= cnt + 32'd1;
                    if (cnt == RC_LAST) begin
                        core.i2c_en <= 1'b1;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Self-checking bench for i2c_master_arbiter: transaction-level model plus
// directed scenarios with literal expectations.
module tb_i2c_master_arbiter;
    localparam int TO = 50;
    localparam int RC = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_0 = 1'b0;
    logic        req_1 = 1'b0;
    logic [1:0]  mode_0 = '0;
    logic [1:0]  mode_1 = '0;
    logic [6:0]  slave_addr_0 = '0;
    logic [6:0]  slave_addr_1 = '0;
    logic [7:0]  reg_addr_0 = '0;
    logic [7:0]  reg_addr_1 = '0;
    logic [1:0]  burst_len_0 = '0;
    logic [1:0]  burst_len_1 = '0;
    logic [31:0] tx_data_0 = '0;
    logic [31:0] tx_data_1 = '0;
    logic        gnt_0, gnt_1, done_0, done_1, err_0, err_1;
    logic [31:0] rx_data_0, rx_data_1;

    i2c_master_arbiter_if bus();

    i2c_master_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .RECOVER_CYCLES(RC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_0(req_0),
        .req_1(req_1),
        .mode_0(mode_0),
        .mode_1(mode_1),
        .slave_addr_0(slave_addr_0),
        .slave_addr_1(slave_addr_1),
        .reg_addr_0(reg_addr_0),
        .reg_addr_1(reg_addr_1),
        .burst_len_0(burst_len_0),
        .burst_len_1(burst_len_1),
        .tx_data_0(tx_data_0),
        .tx_data_1(tx_data_1),
        .gnt_0(gnt_0),
        .gnt_1(gnt_1),
        .done_0(done_0),
        .done_1(done_1),
        .err_0(err_0),
        .err_1(err_1),
        .rx_data_0(rx_data_0),
        .rx_data_1(rx_data_1),
        .core(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          started = 0;
    bit          m_busy, m_cool;
    int          m_age, m_rec, m_own;
    bit          m_last;
    logic [1:0]  e_gnt, e_done, e_err;
    logic        e_en, e_start;
    logic [1:0]  e_mode, e_burst;
    logic [6:0]  e_sa;
    logic [7:0]  e_ra;
    logic [31:0] e_tx, e_rx0, e_rx1;

    always @(posedge clk) begin
        started = 1;
        e_done  = '0;
        e_err   = '0;
        if (reset) begin
            m_busy = 0; m_cool = 0; m_age = 0; m_rec = 0;
            m_own = 0; m_last = 1;
            e_gnt = '0; e_en = 0; e_start = 0;
            e_mode = '0; e_burst = '0; e_sa = '0; e_ra = '0;
            e_tx = '0; e_rx0 = '0; e_rx1 = '0;
        end else if (m_rec > 0) begin
            m_rec--;
            if (m_rec == 0) e_en = 1;
        end else if (m_cool) begin
            m_cool = 0;
        end else if (m_busy) begin
            if (bus.done) begin
                if (bus.rx_done_final) begin
                    if (m_own == 1) e_rx1 = bus.rx_data;
                    else            e_rx0 = bus.rx_data;
                end
                e_done[m_own] = 1;
                m_busy = 0; m_cool = 1; m_last = m_own[0];
                e_gnt = '0; e_start = 0;
            end else if (m_age == TO - 1) begin
                e_err[m_own] = 1;
                m_busy = 0; m_rec = RC; m_last = m_own[0];
                e_gnt = '0; e_start = 0; e_en = 0;
            end else begin
                if (bus.rx_done_final) begin
                    if (m_own == 1) e_rx1 = bus.rx_data;
                    else            e_rx0 = bus.rx_data;
                end
                m_age++;
            end
        end else begin
            e_en = 1;
            if (bus.ready && (req_0 || req_1)) begin
                if (req_0 && req_1) m_own = m_last ? 0 : 1;
                else                m_own = req_1 ? 1 : 0;
                if (m_own == 1) begin
                    e_mode = mode_1; e_sa = slave_addr_1;
                    e_ra = reg_addr_1; e_burst = burst_len_1;
                    e_tx = tx_data_1;
                end else begin
                    e_mode = mode_0; e_sa = slave_addr_0;
                    e_ra = reg_addr_0; e_burst = burst_len_0;
                    e_tx = tx_data_0;
                end
                e_gnt = '0;
                e_gnt[m_own] = 1;
                e_start = 1;
                m_busy = 1; m_age = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ctl", {gnt_1, gnt_0, done_1, done_0, err_1, err_0,
                        bus.i2c_en, bus.start},
                {e_gnt, e_done, e_err, e_en, e_start});
            chk("cmd", {bus.mode, bus.slave_addr, bus.reg_addr,
                        bus.burst_len}, {e_mode, e_sa, e_ra, e_burst});
            chk("tx", bus.tx_data, e_tx);
            chk("rx0", rx_data_0, e_rx0);
            chk("rx1", rx_data_1, e_rx1);
            chk("gnt_excl", gnt_0 & gnt_1, 1'b0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_start(input string nm, output int n);
        n = 0;
        while (bus.start !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk(nm, bus.start, 1'b1);
    endtask

    task automatic pulse_done();
        bus.done = 1;
        step();
        bus.done = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int n, k;
    int ord[4];
    int exp_ord[4] = '{0, 1, 0, 1};

    initial begin
        bus.ready = 1;
        bus.done = 0;
        bus.rx_data = '0;
        bus.rx_done_final = 0;
        mode_0 = 2'b10; slave_addr_0 = 7'h48; reg_addr_0 = 8'h01;
        burst_len_0 = 2'b01; tx_data_0 = 32'h0000ABCD;
        mode_1 = 2'b11; slave_addr_1 = 7'h50; reg_addr_1 = 8'h22;
        burst_len_1 = 2'b11; tx_data_1 = 32'h12345678;
        step();
        step();
        chk("rst_vals", {gnt_0, gnt_1, bus.start, bus.i2c_en,
                         bus.tx_data}, 0);
        reset = 0;
        step();
        chk("en_after_rst", bus.i2c_en, 1'b1);

        // stray rx_done_final outside BUSY, ready low stalls
        bus.rx_done_final = 1; bus.rx_data = 32'h11111111;
        bus.ready = 0; req_0 = 1;
        step();
        bus.rx_done_final = 0; bus.rx_data = '0;
        step();
        step();
        chk("t1_stall", {gnt_0, bus.start}, 2'b00);
        bus.ready = 1;
        step();
        chk("t1_gnt", {gnt_1, gnt_0, bus.start}, 3'b011);
        chk("t1_cmd", {bus.mode, bus.slave_addr, bus.reg_addr,
                       bus.burst_len}, {2'b10, 7'h48, 8'h01, 2'b01});
        chk("t1_tx", bus.tx_data, 32'h0000ABCD);
        req_0 = 0;
        repeat (18) step();
        chk("t1_hold", {gnt_0, bus.start}, 2'b11);
        pulse_done();
        chk("t1_done", {done_0, done_1, bus.start, gnt_0}, 4'b1000);
        step();
        chk("t1_done_once", done_0, 1'b0);

        // read on port 1
        req_1 = 1;
        wait_start("t2_start", n);
        chk("t2_gnt", {gnt_1, gnt_0}, 2'b10);
        req_1 = 0;
        repeat (3) step();
        bus.rx_done_final = 1; bus.rx_data = 32'hDEADBEEF;
        step();
        bus.rx_done_final = 0; bus.rx_data = '0;
        step();
        pulse_done();
        chk("t2_rx1", rx_data_1, 32'hDEADBEEF);
        chk("t2_rx0", rx_data_0, 32'h0);
        chk("t2_done", {done_1, done_0}, 2'b10);

        // continuous contention from reset
        reset = 1;
        step();
        reset = 0;
        req_0 = 1; req_1 = 1;
        for (int i = 0; i < 4; i++) begin
            wait_start("t3_start", n);
            if (i > 0) chk("t3_gap", n, 2);
            ord[i] = gnt_1 ? 1 : 0;
            repeat (3) step();
            pulse_done();
            if (i == 3) begin
                req_0 = 0; req_1 = 0;
            end
        end
        for (int i = 0; i < 4; i++) chk("t3_order", ord[i], exp_ord[i]);

        // timeout, recovery, round-robin to 1
        step();
        req_0 = 1; req_1 = 1;
        wait_start("t4_start", n);
        chk("t4_gnt0", {gnt_1, gnt_0}, 2'b01);
        n = 0;
        while (err_0 !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("t4_err_lat", n, TO);
        chk("t4_no_done", done_0, 1'b0);
        k = 0;
        while (bus.i2c_en !== 1'b1 && k < 20) begin
            k++;
            step();
        end
        chk("t4_en_low", k, RC);
        wait_start("t4_restart", n);
        chk("t4_gnt1", {gnt_1, gnt_0}, 2'b10);
        req_0 = 0; req_1 = 0;
        step();
        pulse_done();

        // done coincides with the timeout limit
        step();
        req_0 = 1;
        wait_start("t5_start", n);
        req_0 = 0;
        repeat (TO - 1) step();
        pulse_done();
        chk("t5_race", {done_0, err_0, bus.i2c_en}, 3'b101);
        step();
        chk("t5_no_err", {err_0, err_1, bus.i2c_en}, 3'b001);

        // reset mid-transaction
        step();
        req_0 = 1;
        wait_start("t6_start", n);
        repeat (5) step();
        reset = 1;
        step();
        chk("t6_rst", {gnt_0, gnt_1, bus.start, bus.i2c_en,
                       done_0, done_1, err_0, err_1}, 0);
        reset = 0; req_0 = 0; req_1 = 1;
        wait_start("t6_start1", n);
        chk("t6_gnt1", {gnt_1, gnt_0}, 2'b10);
        req_1 = 0;
        step();
        pulse_done();
        chk("t6_done1", done_1, 1'b1);
        req_0 = 1; req_1 = 1;
        wait_start("t6_both", n);
        chk("t6_gnt0", {gnt_1, gnt_0}, 2'b01);
        req_0 = 0; req_1 = 0;
        step();
        pulse_done();
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
